// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified memory-port arbiter.
// Bus command codes, arbiter states and transaction owner.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  function automatic logic cmd_active(input logic [1:0] cmd);
    return cmd != BUS_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Transaction timeout counter: cleared on grant, counts while a transaction
// is outstanding, flags expiry on the TIMEOUT-th outstanding cycle.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [CW-1:0] cnt_reg;
      logic          hit;

      assign hit     = (cnt_reg == CW'(TIMEOUT - 1));
      assign expired = active && hit;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (start) begin
          cnt_reg <= '0;
        end else if (active && !hit) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end else begin : g_off
      // TIMEOUT of zero: watchdog disabled, never expires.
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data
// access: data wins, fetch is forced through after MAX_STARVE data grants.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic [1:0]  d_command,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        bus_err
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  arb_state_t  state_reg, state_next;
  owner_t      owner_reg, owner_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic [1:0]  cmd_reg, cmd_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;
  logic        bus_err_reg, bus_err_next;
  logic        is_store_reg, is_store_next;
  logic        grant;
  logic        grant_if;
  logic        d_cand;
  logic        wd_expired;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .active  ((state_reg == ARB_REQ) || (state_reg == ARB_WAIT)),
    .expired (wd_expired)
  );

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    starve_cnt_next = starve_cnt_reg;
    cmd_next        = cmd_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    bus_err_next    = bus_err_reg;
    is_store_next   = is_store_reg;
    grant           = 1'b0;
    grant_if        = 1'b0;
    d_cand          = cmd_active(d_command);

    unique case (state_reg)
      ARB_IDLE: begin
        if (d_cand || if_req) begin
          grant    = 1'b1;
          grant_if = if_req && (!d_cand || (starve_cnt_reg == STARVE_LIMIT));
          state_next = ARB_REQ;
          if (grant_if) begin
            owner_next      = OWN_IF;
            cmd_next        = BUS_LOAD;
            addr_next       = if_addr;
            is_store_next   = 1'b0;
            starve_cnt_next = '0;
          end else begin
            owner_next    = OWN_D;
            cmd_next      = d_command;
            addr_next     = d_addr;
            wdata_next    = d_wdata;
            is_store_next = (d_command == BUS_STORE);
            if (if_req && (starve_cnt_reg < STARVE_LIMIT)) begin
              starve_cnt_next = starve_cnt_reg + 4'd1;
            end
          end
        end
      end
      ARB_REQ, ARB_WAIT: begin
        // Timeout wins over a same-cycle accept or response.
        if (wd_expired) begin
          cmd_next     = BUS_NONE;
          bus_err_next = 1'b1;
          state_next   = ARB_DONE;
          if (owner_reg == OWN_IF) if_rdata_next = '0;
          else                     d_rdata_next  = '0;
        end else if (state_reg == ARB_REQ) begin
          if (mem_req_ready) begin
            cmd_next   = BUS_NONE;
            state_next = is_store_reg ? ARB_DONE : ARB_WAIT;
          end
        end else if (mem_resp_valid) begin
          state_next = ARB_DONE;
          if (owner_reg == OWN_IF) if_rdata_next = mem_resp_data;
          else                     d_rdata_next  = mem_resp_data;
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_IF;
      starve_cnt_reg <= '0;
      cmd_reg        <= BUS_NONE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      bus_err_reg    <= 1'b0;
      is_store_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
      cmd_reg        <= cmd_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      bus_err_reg    <= bus_err_next;
      is_store_reg   <= is_store_next;
    end
  end

  assign mem_command = cmd_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign if_rdata    = if_rdata_reg;
  assign d_rdata     = d_rdata_reg;
  assign bus_err     = bus_err_reg;
  assign if_done     = (state_reg == ARB_DONE) && (owner_reg == OWN_IF);
  assign d_done      = (state_reg == ARB_DONE) && (owner_reg == OWN_D);
  assign if_stall    = if_req && !if_done;
  assign d_stall     = cmd_active(d_command) && !d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store, priority, starvation,
// watchdog timeout and mid-transaction reset, with hand-computed values.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic [1:0]  d_command;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic [1:0]  mem_command;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(
    .MAX_STARVE (4),
    .TIMEOUT    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_done        (if_done),
    .if_stall       (if_stall),
    .d_command      (d_command),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_done         (d_done),
    .d_stall        (d_stall),
    .mem_command    (mem_command),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_command = BUS_NONE; d_addr = '0; d_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    check("rst_mem_command", mem_command, BUS_NONE);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_if_done", if_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_if_stall", if_stall, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch only: ready one cycle late, response two cycles after accept.
    if_req = 1'b1; if_addr = 32'h100;
    #1 check("f_stall_idle", if_stall, 1);
    step();
    check("f_req_cmd", mem_command, BUS_LOAD);
    check("f_req_addr", mem_addr, 32'h100);
    step();
    check("f_req_hold", mem_command, BUS_LOAD);
    mem_req_ready = 1'b1;
    step();
    check("f_cmd_after_accept", mem_command, BUS_NONE);
    mem_req_ready = 1'b0;
    check("f_no_done_wait", if_done, 0);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    step();
    check("f_done", if_done, 1);
    check("f_rdata", if_rdata, 32'h0000_0013);
    check("f_stall_done", if_stall, 0);
    mem_resp_valid = 1'b0; if_req = 1'b0;
    step();
    check("f_done_single", if_done, 0);
    check("f_rdata_hold", if_rdata, 32'h0000_0013);
    $display("txn fetch addr=0x100 rdata=0x%08h", if_rdata);

    // Store only, ready immediately.
    d_command = BUS_STORE; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D; mem_req_ready = 1'b1;
    #1 check("s_stall_idle", d_stall, 1);
    step();
    check("s_req_cmd", mem_command, BUS_STORE);
    check("s_req_addr", mem_addr, 32'h200);
    check("s_req_wdata", mem_wdata, 32'hCAFE_F00D);
    check("s_no_done_req", d_done, 0);
    step();
    check("s_done", d_done, 1);
    check("s_stall_done", d_stall, 0);
    check("s_cmd_done", mem_command, BUS_NONE);
    d_command = BUS_NONE;
    step();
    check("s_done_single", d_done, 0);
    $display("txn store addr=0x200 wdata=0xcafef00d");

    // Simultaneous fetch and data load: data first, then fetch.
    if_req = 1'b1; if_addr = 32'h104;
    d_command = BUS_LOAD; d_addr = 32'h300;
    step();
    check("p_first_addr", mem_addr, 32'h300);
    check("p_starve_one", dut.starve_cnt_reg, 1);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_D00D;
    step();
    check("p_d_done", d_done, 1);
    check("p_d_rdata", d_rdata, 32'h0000_D00D);
    check("p_if_stall", if_stall, 1);
    d_command = BUS_NONE; mem_resp_valid = 1'b0;
    step();
    step();
    check("p_second_addr", mem_addr, 32'h104);
    check("p_second_cmd", mem_command, BUS_LOAD);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1357_9BDF;
    step();
    check("p_if_done", if_done, 1);
    check("p_if_rdata", if_rdata, 32'h1357_9BDF);
    mem_resp_valid = 1'b0; if_req = 1'b0;
    step();
    check("p_starve_clear", dut.starve_cnt_reg, 0);
    $display("txn priority d=0x%08h if=0x%08h", d_rdata, if_rdata);

    // Back-to-back stores with a waiting fetch: fifth arbitration goes to IF.
    if_req = 1'b1; if_addr = 32'h800; d_command = BUS_STORE;
    for (int k = 0; k < 4; k++) begin
      d_addr = 32'h400 + 32'(k * 4); d_wdata = 32'(k);
      step();
      check("st_cmd", mem_command, BUS_STORE);
      check("st_addr", mem_addr, 32'h400 + 32'(k * 4));
      step();
      check("st_done", d_done, 1);
      step();
    end
    step();
    check("st_if_cmd", mem_command, BUS_LOAD);
    check("st_if_addr", mem_addr, 32'h800);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111;
    step();
    check("st_if_done", if_done, 1);
    check("st_if_rdata", if_rdata, 32'h1111_1111);
    check("st_d_stall", d_stall, 1);
    mem_resp_valid = 1'b0; if_req = 1'b0; d_command = BUS_NONE;
    step();
    $display("txn starvation: 4 stores then fetch rdata=0x%08h", if_rdata);

    // Load with no response: watchdog aborts after 8 cycles in REQ+WAIT.
    d_command = BUS_LOAD; d_addr = 32'h500;
    step();
    step();
    for (int c = 3; c <= 8; c++) begin
      step();
      check("t_no_done", d_done, 0);
      check("t_no_err", bus_err, 0);
    end
    step();
    check("t_done", d_done, 1);
    check("t_rdata_zero", d_rdata, 0);
    check("t_bus_err", bus_err, 1);
    check("t_cmd_none", mem_command, BUS_NONE);
    d_command = BUS_NONE; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
    step();
    check("t_idle_no_done", d_done, 0);
    check("t_late_resp", d_rdata, 0);
    step();
    check("t_err_sticky", bus_err, 1);
    check("t_late_resp2", d_rdata, 0);
    mem_resp_valid = 1'b0;
    $display("txn timeout load addr=0x500 bus_err=%0d", bus_err);

    // Reset during WAIT, then a fresh fetch.
    if_req = 1'b1; if_addr = 32'h600;
    step();
    step();
    check("r_in_wait", mem_command, BUS_NONE);
    rst = 1'b1;
    #1;
    check("r_mem_addr", mem_addr, 0);
    check("r_if_rdata", if_rdata, 0);
    check("r_bus_err", bus_err, 0);
    check("r_if_done", if_done, 0);
    check("r_mem_command", mem_command, BUS_NONE);
    if_req = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_DEAD;
    step();
    rst = 1'b0;
    step();
    check("r_resp_ignored", if_rdata, 0);
    check("r_no_done", if_done, 0);
    mem_resp_valid = 1'b0;
    if_req = 1'b1; if_addr = 32'h700;
    step();
    check("r_fresh_cmd", mem_command, BUS_LOAD);
    check("r_fresh_addr", mem_addr, 32'h700);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0050_0093;
    step();
    check("r_fresh_done", if_done, 1);
    check("r_fresh_rdata", if_rdata, 32'h0050_0093);
    mem_resp_valid = 1'b0; if_req = 1'b0;
    step();
    $display("txn reset recovery fetch rdata=0x%08h", if_rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sits between the processor's instruction/data request signals and the single external memory interface.
- Sequences each transaction through request, accept, response and completion, and generates per-requester stalls.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.

Parameters:
MAX_STARVE, 4, consecutive data grants while a fetch waits before fetch is forced to win (range 1-15)
TIMEOUT, 64, cycles allowed in REQ+WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
if_req  in  1  fetch request; held stable until if_done
if_addr  in  32  fetch address
if_rdata  out  32  fetched instruction, valid while if_done
if_done  out  1  one-cycle completion pulse for fetch
if_stall  out  1  fetch waiting
d_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE; held stable until d_done
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid while d_done
d_done  out  1  one-cycle completion pulse for data
d_stall  out  1  data access waiting
mem_command  out  2  command to memory (BUS_NONE when idle)
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_req_ready  in  1  memory accepts the command this cycle
mem_resp_valid  in  1  load response valid
mem_resp_data  in  32  load response data
bus_err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset values: state IDLE; starve_cnt 0; mem_command BUS_NONE; mem_addr 0; mem_wdata 0; if_rdata 0; d_rdata 0; if_done 0; d_done 0; bus_err 0. Reset mid-transaction abandons it and discards any later mem_resp_valid.
- States are IDLE, REQ, WAIT and DONE. owner (IF or D) is latched on grant.
- IDLE arbitration, each cycle:
  - A data candidate exists when d_command != BUS_NONE. A fetch candidate exists when if_req is high.
  - The winner is D, unless if_req is high and starve_cnt == MAX_STARVE, in which case IF wins.
  - With a single candidate, that candidate wins.
  - On a grant: latch owner, load the registered mem_command/mem_addr/mem_wdata, and go to REQ. A fetch always issues BUS_LOAD.
- REQ: hold mem_* stable until mem_req_ready is sampled high. Then:
  - mem_command becomes BUS_NONE.
  - A store goes to DONE.
  - A load goes to WAIT.
- WAIT: on mem_resp_valid, latch mem_resp_data into the owner's rdata and go to DONE.
  - Memory never responds in the acceptance cycle.
  - mem_resp_valid outside WAIT is ignored.
- DONE: the owner's done output is high for exactly this one cycle, no arbitration occurs, and the next state is IDLE.
  - The requester drops or changes its request at the edge that ends DONE.
  - Minimum latency from grant: store 3 cycles (IDLE, REQ, DONE); load 4 cycles.
- starve_cnt:
  - On a D grant with if_req high: increment, saturating at MAX_STARVE.
  - On an IF grant: clear to 0.
  - Otherwise: hold.
- Watchdog (TIMEOUT > 0):
  - A cycle counter clears on entry to REQ and counts through REQ and WAIT.
  - When it reaches TIMEOUT: drive mem_command to BUS_NONE, set the owner rdata to 0, set bus_err (sticky until rst), and go to DONE.
  - A response arriving later is ignored.
- Stalls (combinational):
  - if_stall = if_req && !(state==DONE && owner==IF)
  - d_stall = (d_command != BUS_NONE) && !(state==DONE && owner==D)
- A requester that deasserts before its grant is simply not selected. Deasserting after the grant is illegal, and the transaction completes regardless.

Decomposition:
- The shared defines header supplies the BUS_NONE/BUS_LOAD/BUS_STORE encodings, a state enum (ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_DONE), and an owner enum (OWN_IF, OWN_D).
- One sub-module is natural: arb_watchdog, the timeout counter with start/clear/expire.

Test Plan:
- Fetch only, if_addr=0x100, ready 1 cycle after issue, response 2 cycles after accept with 0x00000013 -> if_rdata=0x00000013 with a single if_done pulse; mem_command returns to BUS_NONE after accept.
- Store only, d_addr=0x200, d_wdata=0xCAFEF00D, ready immediately -> mem_wdata=0xCAFEF00D during REQ; d_done 2 cycles after grant; memory sees no load.
- Simultaneous if_req and d_command=BUS_LOAD -> D granted first, IF served next, starve_cnt returns to 0 after the IF grant.
- Back-to-back stores with if_req held, MAX_STARVE=4 -> 4 data grants, then an IF grant on the 5th arbitration even though d_command is still active.
- TIMEOUT=8, load with memory never responding -> after 8 cycles: bus_err=1, d_done pulse with d_rdata=0, state returns to IDLE; a late mem_resp_valid is ignored.
- rst asserted in WAIT -> all outputs return to reset values immediately; after release, a fresh fetch completes normally.
